code_conv_arbiter: RTL and testbench

- Shares one 8,4,-2,-1-to-BCD/Gray digit converter between two requesters, with round-robin arbitration and a single registered output stage.
- Each requester sends a 4-bit 8,4,-2,-1 digit and a mode bit over valid/ready.
- The winner's digit is converted and presented on one output port, tagged with its source and an illegal-code flag.
- Per-requester saturating error counters record illegal codes for the digit-entry front end.

---
 rtl/code_conv_pkg.sv | 46 ++++
 rtl/code_conv_arbiter_if.sv | 30 +++
 rtl/code_conv_arbiter_digit_conv.sv | 21 ++
 rtl/code_conv_arbiter.sv | 92 +++++++++
 tb/tb_code_conv_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/code_conv_pkg.sv
// Shared types, constants and the 8,4,-2,-1 digit conversion used by the arbiter.
package code_conv_pkg;

   localparam logic MODE_BCD  = 1'b0;
   localparam logic MODE_GRAY = 1'b1;

   // Six 4-bit patterns that have no decimal meaning in 8,4,-2,-1 code
   localparam logic [3:0] ILL_0001 = 4'b0001;
   localparam logic [3:0] ILL_0010 = 4'b0010;
   localparam logic [3:0] ILL_0011 = 4'b0011;
   localparam logic [3:0] ILL_1100 = 4'b1100;
   localparam logic [3:0] ILL_1101 = 4'b1101;
   localparam logic [3:0] ILL_1110 = 4'b1110;

   function automatic logic is_illegal(input logic [3:0] code);
      return (code == ILL_0001) || (code == ILL_0010) || (code == ILL_0011) ||
             (code == ILL_1100) || (code == ILL_1101) || (code == ILL_1110);
   endfunction

   // Returns {err, data[3:0]}; illegal codes give data 0000 with err set
   function automatic logic [4:0] conv_digit(input logic [3:0] code, input logic mode);
      logic [3:0] bcd;
      logic [3:0] gray;
      bcd = 4'd0;
      case (code)
         4'b0000: bcd = 4'd0;
         4'b0111: bcd = 4'd1;
         4'b0110: bcd = 4'd2;
         4'b0101: bcd = 4'd3;
         4'b0100: bcd = 4'd4;
         4'b1011: bcd = 4'd5;
         4'b1010: bcd = 4'd6;
         4'b1001: bcd = 4'd7;
         4'b1000: bcd = 4'd8;
         4'b1111: bcd = 4'd9;
         default: bcd = 4'd0;
      endcase
      // Reflected binary Gray of the decimal value
      gray = bcd ^ {1'b0, bcd[3:1]};
      if (is_illegal(code)) begin
         return 5'b1_0000;
      end
      return {1'b0, (mode == MODE_BCD) ? bcd : gray};
   endfunction

endpackage

// File: rtl/code_conv_arbiter_if.sv
// Handshake bundle: two digit requesters in, one converted-digit stream out.
interface code_conv_arbiter_if;

   logic       req0_valid;
   logic [3:0] req0_code;
   logic       req0_mode;
   logic       req0_ready;
   logic       req1_valid;
   logic [3:0] req1_code;
   logic       req1_mode;
   logic       req1_ready;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_src;
   logic       out_err;

   // Requesters and consumer side
   modport master (
      output req0_valid, req0_code, req0_mode, req1_valid, req1_code, req1_mode, out_ready,
      input  req0_ready, req1_ready, out_valid, out_data, out_src, out_err
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_code, req0_mode, req1_valid, req1_code, req1_mode, out_ready,
      output req0_ready, req1_ready, out_valid, out_data, out_src, out_err
   );

endinterface

// File: rtl/code_conv_arbiter_digit_conv.sv
// Combinational 8,4,-2,-1 to BCD/Gray converter for a single digit.
module digit_conv
   import code_conv_pkg::*;
(
   input  logic [3:0] code,
   input  logic       mode,
   output logic [3:0] data,
   output logic       err
);

   logic [4:0] res;

   // Conversion is entirely the package function, so bench and arbiter share one table
   always_comb begin
      res = conv_digit(code, mode);
   end

   assign data = res[3:0];
   assign err  = res[4];

endmodule

// File: rtl/code_conv_arbiter.sv
// Round-robin arbiter sharing one digit converter between two requesters,
// with a single registered output slot and per-requester illegal-code counters.
module code_conv_arbiter
   import code_conv_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   code_conv_arbiter_if.slave bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] err_cnt0,
   output logic [CNT_W-1:0] err_cnt1
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic       out_valid_q;
   logic [3:0] out_data_q;
   logic       out_src_q;
   logic       out_err_q;
   logic       last_grant;
   logic       slot_free;
   logic       grant0;
   logic       grant1;
   logic       acc0;
   logic       acc1;
   logic [3:0] sel_code;
   logic       sel_mode;
   logic [3:0] conv_data;
   logic       conv_err;

   // Grant: a lone valid requester wins; on contention the one not served last wins
   always_comb begin
      slot_free = ~out_valid_q | bus.out_ready;
      grant0    = bus.req0_valid & (~bus.req1_valid | last_grant);
      grant1    = bus.req1_valid & (~bus.req0_valid | ~last_grant);
      acc0      = slot_free & grant0;
      acc1      = slot_free & grant1;
      sel_code  = grant1 ? bus.req1_code : bus.req0_code;
      sel_mode  = grant1 ? bus.req1_mode : bus.req0_mode;
   end

   digit_conv u_conv (
      .code (sel_code),
      .mode (sel_mode),
      .data (conv_data),
      .err  (conv_err)
   );

   // Output slot: load on accept, drain when consumed, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 4'd0;
         out_src_q   <= 1'b0;
         out_err_q   <= 1'b0;
         last_grant  <= 1'b1;
      end else if (acc0 | acc1) begin
         out_valid_q <= 1'b1;
         out_data_q  <= conv_data;
         out_src_q   <= acc1;
         out_err_q   <= conv_err;
         last_grant  <= acc1;
      end else if (out_valid_q & bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Saturating illegal-code counters; clear beats a same-edge increment
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         err_cnt0 <= '0;
         err_cnt1 <= '0;
      end else begin
         if (acc0 && conv_err && (err_cnt0 != CNT_MAX)) begin
            err_cnt0 <= err_cnt0 + 1'b1;
         end
         if (acc1 && conv_err && (err_cnt1 != CNT_MAX)) begin
            err_cnt1 <= err_cnt1 + 1'b1;
         end
      end
   end

   assign bus.req0_ready = acc0;
   assign bus.req1_ready = acc1;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_src    = out_src_q;
   assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Directed bench for code_conv_arbiter with hand-computed expectations.
module tb_code_conv_arbiter;

   logic       clk;
   logic       rst;
   logic       cnt_clr;
   logic [1:0] err_cnt0;
   logic [1:0] err_cnt1;
   int         nvec;
   int         nerr;

   code_conv_arbiter_if bus();

   code_conv_arbiter #(.CNT_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .cnt_clr  (cnt_clr),
      .err_cnt0 (err_cnt0),
      .err_cnt1 (err_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-written {err, data} per code for each mode (illegal = 5'h10)
   logic [4:0] exp_bcd  [16];
   logic [4:0] exp_gray [16];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_reqs();
      bus.req0_valid = 1'b0;
      bus.req0_code  = 4'd0;
      bus.req0_mode  = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req1_code  = 4'd0;
      bus.req1_mode  = 1'b0;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      exp_bcd  = '{5'h00, 5'h10, 5'h10, 5'h10, 5'h04, 5'h03, 5'h02, 5'h01,
                   5'h08, 5'h07, 5'h06, 5'h05, 5'h10, 5'h10, 5'h10, 5'h09};
      exp_gray = '{5'h00, 5'h10, 5'h10, 5'h10, 5'h06, 5'h02, 5'h03, 5'h01,
                   5'h0C, 5'h04, 5'h05, 5'h07, 5'h10, 5'h10, 5'h10, 5'h0D};

      // Reset
      idle_reqs();
      bus.out_ready = 1'b0;
      cnt_clr = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 8'(bus.out_valid), 8'h0);
      chk("rst_out_data",  8'(bus.out_data),  8'h0);
      chk("rst_out_src",   8'(bus.out_src),   8'h0);
      chk("rst_out_err",   8'(bus.out_err),   8'h0);
      chk("rst_cnt0",      8'(err_cnt0),      8'h0);
      chk("rst_cnt1",      8'(err_cnt1),      8'h0);

      // Single requester, latency one cycle
      bus.out_ready  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_code  = 4'b0111;
      bus.req0_mode  = 1'b0;
      #1;
      chk("single_ready0", 8'(bus.req0_ready), 8'h1);
      tick();
      bus.req0_valid = 1'b0;
      chk("single_valid", 8'(bus.out_valid), 8'h1);
      chk("single_data",  8'(bus.out_data),  8'h1);
      chk("single_src",   8'(bus.out_src),   8'h0);
      chk("single_err",   8'(bus.out_err),   8'h0);
      tick();
      chk("single_drain", 8'(bus.out_valid), 8'h0);

      // Round-robin under continuous contention, starting fresh from reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_code  = 4'b1000;
      bus.req0_mode  = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req1_code  = 4'b1111;
      bus.req1_mode  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ready0", 8'(bus.req0_ready), (i % 2 == 0) ? 8'h1 : 8'h0);
         chk("rr_ready1", 8'(bus.req1_ready), (i % 2 == 0) ? 8'h0 : 8'h1);
         tick();
         chk("rr_src",  8'(bus.out_src),  (i % 2 == 0) ? 8'h0 : 8'h1);
         chk("rr_data", 8'(bus.out_data), (i % 2 == 0) ? 8'hC : 8'h9);
         chk("rr_valid", 8'(bus.out_valid), 8'h1);
      end
      idle_reqs();
      tick();
      chk("rr_drain", 8'(bus.out_valid), 8'h0);

      // Backpressure: hold src1 word 0101 while both request
      bus.out_ready  = 1'b0;
      bus.req1_valid = 1'b1;
      bus.req1_code  = 4'b1011;
      bus.req1_mode  = 1'b0;
      tick();
      bus.req0_valid = 1'b1;
      bus.req0_code  = 4'b0100;
      bus.req0_mode  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready0", 8'(bus.req0_ready), 8'h0);
         chk("bp_ready1", 8'(bus.req1_ready), 8'h0);
         tick();
         chk("bp_valid", 8'(bus.out_valid), 8'h1);
         chk("bp_data",  8'(bus.out_data),  8'h5);
         chk("bp_src",   8'(bus.out_src),   8'h1);
         chk("bp_err",   8'(bus.out_err),   8'h0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("rel_ready0", 8'(bus.req0_ready), 8'h1);
      chk("rel_ready1", 8'(bus.req1_ready), 8'h0);
      tick();
      chk("rel_valid", 8'(bus.out_valid), 8'h1);
      chk("rel_src",   8'(bus.out_src),   8'h0);
      chk("rel_data",  8'(bus.out_data),  8'h4);
      idle_reqs();
      tick();
      chk("rel_drain", 8'(bus.out_valid), 8'h0);

      // Illegal codes from requester 1
      bus.req1_valid = 1'b1;
      bus.req1_mode  = 1'b1;
      bus.req1_code  = 4'b1101;
      tick();
      chk("ill1_data", 8'(bus.out_data), 8'h0);
      chk("ill1_err",  8'(bus.out_err),  8'h1);
      chk("ill1_src",  8'(bus.out_src),  8'h1);
      bus.req1_code  = 4'b0010;
      tick();
      bus.req1_valid = 1'b0;
      chk("ill2_data", 8'(bus.out_data), 8'h0);
      chk("ill2_err",  8'(bus.out_err),  8'h1);
      chk("ill_cnt1",  8'(err_cnt1),     8'h2);
      chk("ill_cnt0",  8'(err_cnt0),     8'h0);
      tick();

      // Counter saturation on requester 0, then clear beating an increment
      bus.req0_valid = 1'b1;
      bus.req0_mode  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: bus.req0_code = 4'b0001;
            1: bus.req0_code = 4'b0011;
            2: bus.req0_code = 4'b1100;
            3: bus.req0_code = 4'b1110;
            default: bus.req0_code = 4'b1101;
         endcase
         tick();
         chk("sat_cnt0", 8'(err_cnt0), (i < 3) ? 8'(i + 1) : 8'h3);
      end
      bus.req0_code = 4'b0001;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_cnt0", 8'(err_cnt0), 8'h0);
      chk("clr_cnt1", 8'(err_cnt1), 8'h0);
      chk("clr_acc_err", 8'(bus.out_err), 8'h1);
      idle_reqs();
      tick();

      // Sweep all codes in both modes through requester 0
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 16; c++) begin
            bus.req0_valid = 1'b1;
            bus.req0_code  = 4'(c);
            bus.req0_mode  = 1'(m);
            tick();
            chk($sformatf("sweep_m%0d_c%0d", m, c), {3'b0, bus.out_err, bus.out_data},
                {3'b0, (m == 0) ? exp_bcd[c] : exp_gray[c]});
         end
      end
      idle_reqs();
      tick();

      // Reset while a word is held under backpressure
      bus.out_ready  = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_code  = 4'b0111;
      bus.req0_mode  = 1'b0;
      tick();
      bus.req0_valid = 1'b0;
      chk("pre_rst_valid", 8'(bus.out_valid), 8'h1);
      chk("pre_rst_cnt0",  8'(err_cnt0),      8'h3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 8'(bus.out_valid), 8'h0);
      chk("mid_rst_cnt0",  8'(err_cnt0),      8'h0);
      chk("mid_rst_cnt1",  8'(err_cnt1),      8'h0);
      bus.out_ready  = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_code  = 4'b0110;
      bus.req1_valid = 1'b1;
      bus.req1_code  = 4'b0101;
      #1;
      chk("post_rst_ready0", 8'(bus.req0_ready), 8'h1);
      chk("post_rst_ready1", 8'(bus.req1_ready), 8'h0);
      tick();
      chk("post_rst_src",  8'(bus.out_src),  8'h0);
      chk("post_rst_data", 8'(bus.out_data), 8'h2);
      idle_reqs();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
